// File: rtl/fft_din_collector.sv
// Serial-to-parallel frame collector for the FFT butterfly chain: samples are
// stored bit-reversed into ping-pong banks and presented as packed frames.
module fft_din_collector #(
  parameter int WIDTH  = 16,
  parameter int NPOINT = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sin_valid,
  output logic                           sin_busy,
  input  logic [WIDTH-1:0]               sin_real,
  input  logic [WIDTH-1:0]               sin_imag,
  input  logic                           sin_last,
  output logic                           dout_valid,
  input  logic                           dout_busy,
  output logic [WIDTH*(2**NPOINT)-1:0]   dout_real,
  output logic [WIDTH*(2**NPOINT)-1:0]   dout_imag,
  output logic                           frame_err
);

  localparam int N = 2 ** NPOINT;
  localparam logic [NPOINT-1:0] CNT_LAST = NPOINT'(N - 1);

  // Handshakes: a transfer happens on a clock edge where valid is high and
  // busy is low, on both the serial input and the parallel output side.

  logic [WIDTH*N-1:0] bank_real_q [2];
  logic [WIDTH*N-1:0] bank_real_d [2];
  logic [WIDTH*N-1:0] bank_imag_q [2];
  logic [WIDTH*N-1:0] bank_imag_d [2];
  logic [1:0]         full_q, full_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [NPOINT-1:0]  cnt_q, cnt_d;
  logic               frame_err_q, frame_err_d;

  logic accept;
  logic drain;
  int   wr_idx;

  function automatic logic [NPOINT-1:0] bitrev(input logic [NPOINT-1:0] v);
    logic [NPOINT-1:0] r;
    for (int i = 0; i < NPOINT; i++) r[i] = v[NPOINT-1-i];
    return r;
  endfunction

  always_comb begin
    bank_real_d = bank_real_q;
    bank_imag_d = bank_imag_q;
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    cnt_d       = cnt_q;
    frame_err_d = 1'b0;
    accept      = sin_valid && !full_q[wr_bank_q];
    drain       = full_q[rd_bank_q] && !dout_busy;
    wr_idx      = int'(bitrev(cnt_q));

    if (accept) begin
      bank_real_d[wr_bank_q][wr_idx*WIDTH +: WIDTH] = sin_real;
      bank_imag_d[wr_bank_q][wr_idx*WIDTH +: WIDTH] = sin_imag;
      if (cnt_q == CNT_LAST) begin
        // A missing sin_last still completes the frame, but is flagged.
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        cnt_d             = '0;
        frame_err_d       = !sin_last;
      end else if (sin_last) begin
        // Early sin_last drops the partial frame; the bank is reused as-is.
        cnt_d       = '0;
        frame_err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Completion always targets an empty bank and drain a full one, so the
    // two updates to full_d never collide on the same bit.
    if (drain) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_real_q <= '{default: '0};
      bank_imag_q <= '{default: '0};
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      bank_real_q <= bank_real_d;
      bank_imag_q <= bank_imag_d;
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign sin_busy   = full_q[wr_bank_q];
  assign dout_valid = full_q[rd_bank_q];
  assign dout_real  = bank_real_q[rd_bank_q];
  assign dout_imag  = bank_imag_q[rd_bank_q];
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_fft_din_collector.sv
// Directed bench for fft_din_collector: frame ordering, backpressure,
// simultaneous completion/drain, framing errors and mid-stream reset.
module tb_fft_din_collector;

  localparam int W  = 16;
  localparam int NP = 3;
  localparam int N  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             sin_valid;
  logic             sin_busy;
  logic [W-1:0]     sin_real;
  logic [W-1:0]     sin_imag;
  logic             sin_last;
  logic             dout_valid;
  logic             dout_busy;
  logic [W*N-1:0]   dout_real;
  logic [W*N-1:0]   dout_imag;
  logic             frame_err;

  int n_checks = 0;
  int n_errors = 0;

  // Element i of an output frame holds sample number br_tab[i].
  int br_tab [N] = '{0, 4, 2, 6, 1, 5, 3, 7};

  fft_din_collector #(.WIDTH(W), .NPOINT(NP)) dut (
    .clk        (clk),
    .rst        (rst),
    .sin_valid  (sin_valid),
    .sin_busy   (sin_busy),
    .sin_real   (sin_real),
    .sin_imag   (sin_imag),
    .sin_last   (sin_last),
    .dout_valid (dout_valid),
    .dout_busy  (dout_busy),
    .dout_real  (dout_real),
    .dout_imag  (dout_imag),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sample k of a frame with base b carries real=b+k, imag=-(b+k).
  function automatic logic [W*N-1:0] exp_vec(input int base, input bit neg);
    logic [W*N-1:0] r;
    logic [W-1:0]   v;
    for (int i = 0; i < N; i++) begin
      v = W'(base + br_tab[i]);
      if (neg) v = -v;
      r[i*W +: W] = v;
    end
    return r;
  endfunction

  task automatic send_sample(input int val, input bit last);
    int guard;
    logic [W-1:0] re;
    guard     = 0;
    re        = W'(val);
    sin_valid = 1'b1;
    sin_real  = re;
    sin_imag  = -re;
    sin_last  = last;
    while (sin_busy && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: sin_busy stuck at %0b, required 0 within 50 cycles", sin_busy);
    end
    tick();
    sin_valid = 1'b0;
    sin_last  = 1'b0;
  endtask

  task automatic send_frame(input int base, input int count, input int last_k);
    for (int k = 0; k < count; k++) send_sample(base + k, k == last_k);
  endtask

  task automatic test_reset();
    rst = 1'b1; sin_valid = 1'b0; sin_last = 1'b0; dout_busy = 1'b0;
    sin_real = '0; sin_imag = '0;
    tick(); tick();
    n_checks++;
    if (sin_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %0b, required 0", sin_busy); end
    n_checks++;
    if (dout_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %0b, required 0", dout_valid); end
    n_checks++;
    if (dout_real !== '0 || dout_imag !== '0) begin
      n_errors++; $display("FAIL reset_data: real %h imag %h, required 0", dout_real, dout_imag);
    end
    n_checks++;
    if (frame_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %0b, required 0", frame_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single_frame();
    dout_busy = 1'b0;
    send_frame(0, 8, 7);
    n_checks++;
    if (dout_valid !== 1'b1) begin n_errors++; $display("FAIL single_valid: got %0b, required 1", dout_valid); end
    n_checks++;
    if (dout_real !== exp_vec(0, 0)) begin
      n_errors++; $display("FAIL single_real: got %h, required %h", dout_real, exp_vec(0, 0));
    end
    n_checks++;
    if (dout_imag !== exp_vec(0, 1)) begin
      n_errors++; $display("FAIL single_imag: got %h, required %h", dout_imag, exp_vec(0, 1));
    end
    n_checks++;
    if (frame_err !== 1'b0) begin n_errors++; $display("FAIL single_err: got %0b, required 0", frame_err); end
    tick();
    n_checks++;
    if (dout_valid !== 1'b0) begin n_errors++; $display("FAIL single_drained: got %0b, required 0", dout_valid); end
  endtask

  task automatic test_backpressure();
    dout_busy = 1'b1;
    send_frame(16, 8, 7);
    send_frame(32, 8, 7);
    n_checks++;
    if (sin_busy !== 1'b1) begin n_errors++; $display("FAIL bp_busy: got %0b, required 1", sin_busy); end
    // Offer frame 3 sample 0 while full; it must be held off.
    sin_valid = 1'b1; sin_real = W'(48); sin_imag = -W'(48); sin_last = 1'b0;
    tick(); tick(); tick();
    n_checks++;
    if (sin_busy !== 1'b1 || dout_valid !== 1'b1 || dout_real !== exp_vec(16, 0)) begin
      n_errors++; $display("FAIL bp_hold: busy %0b valid %0b real %h, required 1 1 %h",
                           sin_busy, dout_valid, dout_real, exp_vec(16, 0));
    end
    dout_busy = 1'b0;
    tick();
    dout_busy = 1'b1;
    sin_valid = 1'b0;
    n_checks++;
    if (sin_busy !== 1'b0) begin n_errors++; $display("FAIL bp_release_busy: got %0b, required 0", sin_busy); end
    n_checks++;
    if (dout_valid !== 1'b1 || dout_real !== exp_vec(32, 0) || dout_imag !== exp_vec(32, 1)) begin
      n_errors++; $display("FAIL bp_frame2: valid %0b real %h, required 1 %h", dout_valid, dout_real, exp_vec(32, 0));
    end
    send_frame(48, 8, 7);
    n_checks++;
    if (sin_busy !== 1'b1) begin n_errors++; $display("FAIL bp_full_again: got %0b, required 1", sin_busy); end
    dout_busy = 1'b0;
    tick();
    n_checks++;
    if (dout_valid !== 1'b1 || dout_real !== exp_vec(48, 0) || dout_imag !== exp_vec(48, 1)) begin
      n_errors++; $display("FAIL bp_frame3: valid %0b real %h, required 1 %h", dout_valid, dout_real, exp_vec(48, 0));
    end
    tick();
    n_checks++;
    if (dout_valid !== 1'b0 || sin_busy !== 1'b0) begin
      n_errors++; $display("FAIL bp_empty: valid %0b busy %0b, required 0 0", dout_valid, sin_busy);
    end
  endtask

  task automatic test_back_to_back();
    dout_busy = 1'b1;
    send_frame(64, 8, 7);
    send_frame(80, 7, 7);
    // Frame 64 drains on the same edge that completes frame 80.
    dout_busy = 1'b0;
    send_sample(80 + 7, 1'b1);
    dout_busy = 1'b1;
    n_checks++;
    if (dout_valid !== 1'b1 || dout_real !== exp_vec(80, 0) || dout_imag !== exp_vec(80, 1)) begin
      n_errors++; $display("FAIL b2b_data: valid %0b real %h, required 1 %h", dout_valid, dout_real, exp_vec(80, 0));
    end
    n_checks++;
    if (sin_busy !== 1'b0) begin n_errors++; $display("FAIL b2b_busy: got %0b, required 0", sin_busy); end
    dout_busy = 1'b0;
    tick();
    n_checks++;
    if (dout_valid !== 1'b0) begin n_errors++; $display("FAIL b2b_drained: got %0b, required 0", dout_valid); end
  endtask

  task automatic test_framing();
    dout_busy = 1'b0;
    send_frame(96, 5, 4);
    n_checks++;
    if (frame_err !== 1'b1 || dout_valid !== 1'b0) begin
      n_errors++; $display("FAIL early_last: err %0b valid %0b, required 1 0", frame_err, dout_valid);
    end
    tick();
    n_checks++;
    if (frame_err !== 1'b0) begin n_errors++; $display("FAIL early_pulse: got %0b, required 0", frame_err); end
    send_frame(112, 8, 7);
    n_checks++;
    if (dout_valid !== 1'b1 || dout_real !== exp_vec(112, 0) || frame_err !== 1'b0) begin
      n_errors++; $display("FAIL early_recover: valid %0b err %0b real %h, required 1 0 %h",
                           dout_valid, frame_err, dout_real, exp_vec(112, 0));
    end
    tick();
    send_frame(128, 8, -1);
    n_checks++;
    if (frame_err !== 1'b1 || dout_valid !== 1'b1) begin
      n_errors++; $display("FAIL missing_last: err %0b valid %0b, required 1 1", frame_err, dout_valid);
    end
    n_checks++;
    if (dout_real !== exp_vec(128, 0) || dout_imag !== exp_vec(128, 1)) begin
      n_errors++; $display("FAIL missing_data: real %h, required %h", dout_real, exp_vec(128, 0));
    end
    tick();
    n_checks++;
    if (frame_err !== 1'b0 || dout_valid !== 1'b0) begin
      n_errors++; $display("FAIL missing_after: err %0b valid %0b, required 0 0", frame_err, dout_valid);
    end
  endtask

  task automatic test_reset_mid();
    dout_busy = 1'b1;
    send_frame(144, 8, 7);
    send_frame(160, 3, 7);
    rst = 1'b1;
    tick();
    n_checks++;
    if (dout_valid !== 1'b0 || sin_busy !== 1'b0 || frame_err !== 1'b0) begin
      n_errors++; $display("FAIL mid_reset_ctrl: valid %0b busy %0b err %0b, required 0 0 0",
                           dout_valid, sin_busy, frame_err);
    end
    n_checks++;
    if (dout_real !== '0 || dout_imag !== '0) begin
      n_errors++; $display("FAIL mid_reset_data: real %h imag %h, required 0", dout_real, dout_imag);
    end
    rst = 1'b0;
    dout_busy = 1'b0;
    tick();
    send_frame(176, 8, 7);
    n_checks++;
    if (dout_valid !== 1'b1 || dout_real !== exp_vec(176, 0) || dout_imag !== exp_vec(176, 1)) begin
      n_errors++; $display("FAIL mid_reset_frame: valid %0b real %h, required 1 %h", dout_valid, dout_real, exp_vec(176, 0));
    end
    tick();
    n_checks++;
    if (dout_valid !== 1'b0) begin n_errors++; $display("FAIL mid_reset_drain: got %0b, required 0", dout_valid); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_framing();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
